// File: rtl/eeprom_txn_engine.sv
// EEPROM transaction sequencer: variable-length reads/writes over a byte-level
// I2C master, with page-split writes, ACK polling and an encoded error result.
`default_nettype none

module eeprom_txn_engine #(
  parameter int         BYTES    = 4,
  parameter logic [6:0] SLA7     = 7'h58,
  parameter int         PAGE     = 32,
  parameter int         POLL_MAX = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               wr_i,
  input  logic [15:0]        addr_i,
  input  logic [4:0]         len_i,
  input  logic [BYTES*8-1:0] din_i,
  output logic [BYTES*8-1:0] dout_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         err_o,
  output logic               i2c_start_o,
  output logic               i2c_stop_o,
  output logic               i2c_write_o,
  output logic               i2c_read_o,
  output logic [7:0]         i2c_data_in_o,
  output logic               ack_in_o,
  input  logic               i2c_busy_i,
  input  logic               i2c_done_i,
  input  logic               i2c_ack_err_i,
  input  logic [7:0]         i2c_data_out_i
);

  localparam logic [15:0] c_PAGE_MASK = 16'(PAGE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_SLA_W, S_ADDR_H, S_ADDR_L, S_WDATA, S_RSTART, S_SLA_R,
    S_RDATA, S_STOP, S_POLL_START, S_POLL_SLA, S_POLL_STOP, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [15:0]        addr_q, addr_d;
  logic [4:0]         rem_q, rem_d;
  logic [4:0]         idx_q, idx_d;
  logic [BYTES*8-1:0] din_q, din_d;
  logic [BYTES*8-1:0] dout_q, dout_d;
  logic [1:0]         err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pend_q, pend_d;
  logic [7:0]         poll_cnt_q, poll_cnt_d;
  logic               poll_ack_q, poll_ack_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               write_q, write_d;
  logic               read_q, read_d;
  logic [7:0]         data_q, data_d;
  logic               ack_q, ack_d;

  logic               w_issue;
  logic               w_fin;
  logic [15:0]        w_addr_inc;
  logic [7:0]         w_wbyte;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    din_d      = din_q;
    dout_d     = dout_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pend_d     = pend_q;
    poll_cnt_d = poll_cnt_q;
    poll_ack_d = poll_ack_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    write_d    = 1'b0;
    read_d     = 1'b0;
    data_d     = data_q;
    ack_d      = ack_q;

    // One command in flight at a time; the strobe goes out the cycle after issue.
    w_issue    = !pend_q && !i2c_busy_i;
    w_fin      = pend_q && i2c_done_i;
    w_addr_inc = addr_q + 16'd1;
    w_wbyte    = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      if (idx_q == 5'(k)) w_wbyte = din_q[(BYTES-1-k)*8 +: 8];
    end

    if (w_fin) pend_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          wr_d   = wr_i;
          addr_d = addr_i;
          rem_d  = len_i;
          idx_d  = 5'd0;
          din_d  = din_i;
          dout_d = '0;
          err_d  = 2'd0;
          busy_d = 1'b1;
          if (len_i == 5'd0 || len_i > 5'(BYTES)) begin
            err_d   = 2'd3;
            state_d = S_DONE;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START, S_RSTART, S_POLL_START: begin
        if (w_issue) begin
          start_d = 1'b1;
          pend_d  = 1'b1;
        end
        if (w_fin) begin
          state_d = (state_q == S_START)  ? S_SLA_W :
                    (state_q == S_RSTART) ? S_SLA_R : S_POLL_SLA;
        end
      end
      S_SLA_W, S_ADDR_H, S_ADDR_L, S_SLA_R: begin
        if (w_issue) begin
          write_d = 1'b1;
          pend_d  = 1'b1;
          data_d  = (state_q == S_SLA_W)  ? {SLA7, 1'b0} :
                    (state_q == S_SLA_R)  ? {SLA7, 1'b1} :
                    (state_q == S_ADDR_H) ? addr_q[15:8] : addr_q[7:0];
        end
        if (w_fin) begin
          if (i2c_ack_err_i) begin
            err_d   = 2'd1;
            state_d = S_STOP;
          end else begin
            state_d = (state_q == S_SLA_W)  ? S_ADDR_H :
                      (state_q == S_ADDR_H) ? S_ADDR_L :
                      (state_q == S_SLA_R)  ? S_RDATA  :
                      (wr_q ? S_WDATA : S_RSTART);
          end
        end
      end
      S_WDATA: begin
        if (w_issue) begin
          write_d = 1'b1;
          pend_d  = 1'b1;
          data_d  = w_wbyte;
        end
        if (w_fin) begin
          if (i2c_ack_err_i) begin
            err_d   = 2'd1;
            state_d = S_STOP;
          end else begin
            addr_d = w_addr_inc;
            rem_d  = rem_q - 5'd1;
            idx_d  = idx_q + 5'd1;
            // Close the segment on the last byte or when the page (or 64K) wraps.
            if (rem_q == 5'd1 || (w_addr_inc & c_PAGE_MASK) == 16'd0) state_d = S_STOP;
          end
        end
      end
      S_RDATA: begin
        if (w_issue) begin
          read_d = 1'b1;
          pend_d = 1'b1;
          ack_d  = (rem_q == 5'd1);
        end
        if (w_fin) begin
          for (int k = 0; k < BYTES; k++) begin
            if (idx_q == 5'(k)) dout_d[(BYTES-1-k)*8 +: 8] = i2c_data_out_i;
          end
          rem_d = rem_q - 5'd1;
          idx_d = idx_q + 5'd1;
          if (rem_q == 5'd1) state_d = S_STOP;
        end
      end
      S_STOP, S_POLL_STOP: begin
        if (w_issue) begin
          stop_d = 1'b1;
          pend_d = 1'b1;
        end
        if (w_fin) begin
          if (state_q == S_STOP) begin
            if (err_q != 2'd0 || !wr_q) begin
              state_d = S_DONE;
            end else begin
              poll_cnt_d = 8'd0;
              state_d    = S_POLL_START;
            end
          end else if (poll_ack_q) begin
            state_d = (rem_q == 5'd0) ? S_DONE : S_START;
          end else if (poll_cnt_q == 8'(POLL_MAX)) begin
            err_d   = 2'd2;
            state_d = S_DONE;
          end else begin
            state_d = S_POLL_START;
          end
        end
      end
      S_POLL_SLA: begin
        if (w_issue) begin
          write_d = 1'b1;
          pend_d  = 1'b1;
          data_d  = {SLA7, 1'b0};
        end
        if (w_fin) begin
          poll_ack_d = !i2c_ack_err_i;
          if (i2c_ack_err_i) poll_cnt_d = poll_cnt_q + 8'd1;
          state_d = S_POLL_STOP;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= 16'd0;
      rem_q      <= 5'd0;
      idx_q      <= 5'd0;
      din_q      <= '0;
      dout_q     <= '0;
      err_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      poll_cnt_q <= 8'd0;
      poll_ack_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      data_q     <= 8'h00;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      din_q      <= din_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      poll_cnt_q <= poll_cnt_d;
      poll_ack_q <= poll_ack_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      write_q    <= write_d;
      read_q     <= read_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
    end
  end

  assign dout_o        = dout_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign i2c_start_o   = start_q;
  assign i2c_stop_o    = stop_q;
  assign i2c_write_o   = write_q;
  assign i2c_read_o    = read_q;
  assign i2c_data_in_o = data_q;
  assign ack_in_o      = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_eeprom_txn_engine.sv
// Bench for eeprom_txn_engine: bus-level EEPROM stand-in plus a transaction-level
// reference model predicting the bus transcript, err and dout.
`timescale 1ns/1ps
`default_nettype none

module tb_eeprom_txn_engine;
  localparam int         BYTES    = 4;
  localparam int         PAGE     = 32;
  localparam int         POLL_MAX = 3;
  localparam logic [6:0] SLA7     = 7'h58;
  localparam logic [7:0] SLAW     = {SLA7, 1'b0};
  localparam logic [7:0] SLAR     = {SLA7, 1'b1};
  localparam logic [15:0] TS      = 16'h1000;
  localparam logic [15:0] TP      = 16'h2000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [4:0]  len = 5'd0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic busy, done, ack_in;
  logic [1:0] err;
  logic st, sp, wcmd, rcmd;
  logic [7:0] i2c_din;
  logic i2c_busy = 1'b0, i2c_done = 1'b0, i2c_ack_err = 1'b0;
  logic [7:0] i2c_dout = 8'h00;

  eeprom_txn_engine #(.BYTES(BYTES), .SLA7(SLA7), .PAGE(PAGE), .POLL_MAX(POLL_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wr_i(wr), .addr_i(addr), .len_i(len),
    .din_i(din), .dout_o(dout), .busy_o(busy), .done_o(done), .err_o(err),
    .i2c_start_o(st), .i2c_stop_o(sp), .i2c_write_o(wcmd), .i2c_read_o(rcmd),
    .i2c_data_in_o(i2c_din), .ack_in_o(ack_in), .i2c_busy_i(i2c_busy),
    .i2c_done_i(i2c_done), .i2c_ack_err_i(i2c_ack_err), .i2c_data_out_i(i2c_dout)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [15:0] act_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  dev_mem[0:65535];
  logic [7:0]  ref_mem[0:65535];
  int          cfg_nbusy = 0, cfg_inj = -1;
  logic [1:0]  exp_err = 2'd0;
  logic [31:0] exp_dout = 32'h0;
  bit          got_done = 0;
  int          m_wc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, expv, $time);
    end
  endtask

  // EEPROM + I2C master stand-in: random command latency, page memory, write-cycle busy.
  int lat = 0, dev_busy = 0, dwc = 0, fb = 0;
  logic [15:0] ptr = 16'h0;
  bit wrote = 0, fnack = 0, dnk = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_busy <= 1'b0; i2c_done <= 1'b0; i2c_ack_err <= 1'b0; i2c_dout <= 8'h00;
      lat = 0; dev_busy = 0; dwc = 0; fb = 0; wrote = 0; fnack = 0;
    end else begin
      i2c_done <= 1'b0;
      if (req) begin dev_busy = 0; dwc = 0; end
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin i2c_done <= 1'b1; i2c_busy <= 1'b0; end
      end
      if (st || sp || wcmd || rcmd) begin
        lat = $urandom_range(1, 3);
        i2c_busy <= 1'b1;
        i2c_ack_err <= 1'b0;
        if (st) begin
          act_q.push_back(TS); fb = 0; fnack = 0;
        end else if (sp) begin
          act_q.push_back(TP);
          if (wrote && !fnack) dev_busy = cfg_nbusy;
          wrote = 0;
        end else if (wcmd) begin
          dnk = (dwc == cfg_inj) || (fb == 0 && dev_busy > 0);
          if (fb == 0 && dev_busy > 0) dev_busy--;
          dwc++;
          act_q.push_back({8'h30, i2c_din});
          if (dnk) fnack = 1;
          else if (fb == 1) ptr[15:8] = i2c_din;
          else if (fb == 2) ptr[7:0] = i2c_din;
          else if (fb >= 3) begin dev_mem[ptr] = i2c_din; ptr++; wrote = 1; end
          fb++;
          i2c_ack_err <= dnk;
        end else begin
          act_q.push_back({4'h4, 3'b000, ack_in, 8'h00});
          i2c_dout <= dev_mem[ptr];
          ptr++;
        end
      end
    end
  end

  // Reference model: transaction-level description of the expected bus traffic.
  task automatic mw(input logic [7:0] b, output bit nk);
    exp_q.push_back({8'h30, b});
    nk = (m_wc == cfg_inj);
    m_wc++;
  endtask

  task automatic model_txn(input bit w, input logic [15:0] a0, input int l,
                           input logic [31:0] d, input int nbusy);
    logic [15:0] a; int i, seg, pc; bit nk; logic [7:0] b;
    exp_q.delete(); exp_dout = 32'h0; exp_err = 2'd0; a = a0; m_wc = 0;
    if (l < 1 || l > BYTES) begin exp_err = 2'd3; return; end
    if (w) begin
      i = 0;
      while (i < l) begin
        seg = PAGE - (int'(a) % PAGE);
        if (seg > l - i) seg = l - i;
        exp_q.push_back(TS);
        mw(SLAW, nk);      if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
        mw(a[15:8], nk);   if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
        mw(a[7:0], nk);    if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
        for (int j = 0; j < seg; j++) begin
          b = d[(BYTES-1-(i+j))*8 +: 8];
          mw(b, nk);
          if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
          ref_mem[a] = b;
          a++;
        end
        i += seg;
        exp_q.push_back(TP);
        pc = 0;
        forever begin
          exp_q.push_back(TS); exp_q.push_back({8'h30, SLAW}); exp_q.push_back(TP);
          m_wc++;
          if (pc < nbusy) begin
            pc++;
            if (pc == POLL_MAX) begin exp_err = 2'd2; return; end
          end else break;
        end
      end
    end else begin
      exp_q.push_back(TS);
      mw(SLAW, nk);    if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
      mw(a[15:8], nk); if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
      mw(a[7:0], nk);  if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
      exp_q.push_back(TS);
      mw(SLAR, nk);    if (nk) begin exp_q.push_back(TP); exp_err = 2'd1; return; end
      for (int k = 0; k < l; k++) begin
        exp_q.push_back({4'h4, 3'b000, (k == l - 1), 8'h00});
        exp_dout[(BYTES-1-k)*8 +: 8] = ref_mem[a];
        a++;
      end
      exp_q.push_back(TP);
    end
  endtask

  // Compare process: handshake rules on every strobe, full result on every done.
  int cmp_ns, cmp_bad;
  always @(negedge clk) begin
    if (rst_n) begin
      cmp_ns = int'(st) + int'(sp) + int'(wcmd) + int'(rcmd);
      if (cmp_ns != 0) begin
        chk("strobe_onehot", cmp_ns, 1);
        chk("strobe_vs_busy_done", {i2c_done, i2c_busy}, 0);
      end
      if (done) begin
        chk("busy_at_done", busy, 0);
        chk("err", err, exp_err);
        chk("dout", dout, exp_dout);
        chk("token_count", act_q.size(), exp_q.size());
        cmp_bad = -1;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
          if (cmp_bad < 0 && act_q[i] !== exp_q[i]) cmp_bad = i;
        if (cmp_bad >= 0) chk("token", act_q[cmp_bad], exp_q[cmp_bad]);
        got_done = 1;
      end
    end
  end

  task automatic launch(input bit w, input logic [15:0] a, input int l, input logic [31:0] d,
                        input int nb, input int inj);
    cfg_nbusy = nb; cfg_inj = inj;
    model_txn(w, a, l, d, nb);
    @(posedge clk); #1;
    act_q.delete(); got_done = 0;
    wr = w; addr = a; len = 5'(l); din = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 4000 && !got_done; c++) @(posedge clk);
    if (!got_done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input bit w, input logic [15:0] a, input int l, input logic [31:0] d,
                         input int nb, input int inj);
    launch(w, a, l, d, nb, inj);
    wait_done();
  endtask

  bit          r_w;
  logic [15:0] r_a;
  logic [31:0] r_d;
  int          r_l, r_nb, r_inj, r_seg;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin dev_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    #1;
    chk("rst_outputs", {busy, done, st, sp, wcmd, rcmd, ack_in, err, i2c_din, dout}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Straight write, one poll
    run_txn(1, 16'h0010, 4, 32'hA1B2C3D4, 0, -1);
    chk("w_tokens", act_q.size(), 12);
    chk("w_tok_A1", act_q[4], 16'h30A1);
    chk("w_tok_poll", act_q[10], 16'h30B0);

    // Page split at 0x0020
    run_txn(1, 16'h001E, 4, 32'hA1B2C3D4, 0, -1);
    chk("split_tokens", act_q.size(), 20);
    chk("split_stop1", act_q[6], TP);
    chk("split_addr_lo", act_q[13], 16'h3020);

    // Poll timeout after three NACKed polls
    run_txn(1, 16'h0100, 2, 32'h11223344, 10, -1);
    chk("timeout_err", err, 2);
    chk("timeout_tokens", act_q.size(), 16);

    // Read back
    run_txn(0, 16'h0010, 4, 32'h0, 0, -1);
    chk("rd_dout", dout, 32'hA1B2C3D4);
    chk("rd_rstart", act_q[4], TS);
    chk("rd_sla_r", act_q[5], 16'h30B1);
    chk("rd_ack0", act_q[6], 16'h4000);
    chk("rd_ack_last", act_q[9], 16'h4100);

    // NACK on SLA_W
    run_txn(0, 16'h0010, 4, 32'h0, 0, 0);
    chk("nack_err", err, 1);
    chk("nack_dout", dout, 0);
    chk("nack_tokens", act_q.size(), 3);

    // Bad lengths: busy the cycle after accept, done the next, no bus traffic
    launch(1, 16'h0040, 0, 32'hDEADBEEF, 0, -1);
    chk("len0_busy", busy, 1);
    chk("len0_done_early", done, 0);
    @(posedge clk); #1;
    chk("len0_done", done, 1);
    chk("len0_err", err, 3);
    wait_done();
    chk("len0_no_strobes", act_q.size(), 0);
    run_txn(0, 16'h0040, 5, 32'h0, 0, -1);
    chk("len5_err", err, 3);

    // Randomised transactions
    for (int n = 0; n < 60; n++) begin
      r_w = 1'($urandom_range(0, 1));
      r_a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) r_a[4:2] = 3'b111;
      if ($urandom_range(0, 7) == 0) r_a = 16'hFFFD;
      r_l = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : 5) : $urandom_range(1, 4);
      r_nb = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
      r_d = $urandom;
      r_seg = PAGE - (int'(r_a) % PAGE);
      if (r_seg > r_l) r_seg = r_l;
      r_inj = ($urandom_range(0, 4) == 0) ? $urandom_range(0, r_w ? 2 + r_seg : 3) : -1;
      run_txn(r_w, r_a, r_l, r_d, r_nb, r_inj);
    end

    // Reset while the second data byte is on the bus
    launch(1, 16'h0300, 4, 32'h5A6B7C8D, 0, -1);
    for (int c = 0; c < 500 && act_q.size() < 6; c++) @(posedge clk);
    chk("reached_wdata2", act_q.size() >= 6, 1);
    #2;
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, done, st, sp, wcmd, rcmd, ack_in, err, i2c_din, dout}, 0);
    ref_mem[16'h0300] = 8'h5A;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_txn(1, 16'h0300, 4, 32'h11223344, 1, -1);
    chk("post_rst_first", act_q[0], TS);
    run_txn(0, 16'h0300, 4, 32'h0, 0, -1);
    chk("post_rst_read", dout, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
